nios2_qsys_oci_dct_packer: RTL and testbench
============================================

Name: nios2_qsys_oci_dct_packer

Overview:
- Producer side of the OCI data-trace compression buffer interface.
- Collects 2-bit data-trace codes from the trace front end and packs them into a 30-bit buffer word plus a 4-bit slot count (dct_buffer / dct_count).
- Presents each word to the trace sink or simulation checker through a valid/ready handshake.
- Drives the end-of-test flush sequence that ends with test_has_ended.

Parameters:
- SLOTS, 15, number of code slots per buffer word; dct_count width is 4 bits, so SLOTS must be ≤15.
- CODE_W, 2, width of one trace code; buffer width = SLOTS*CODE_W = 30.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- code_valid  in  1  trace code offered.
- code_in  in  2  trace code value.
- code_ready  out  1  packer accepts code_in this cycle.
- flush  in  1  single-cycle request to emit a partial word.
- dct_buffer  out  30  packed codes.
- dct_count  out  4  number of valid codes in dct_buffer, 1..15.
- dct_valid  out  1  output word valid.
- dct_ready  in  1  sink accepts output word.
- test_ending  in  1  level; simulation is ending, drain everything.
- test_has_ended  out  1  level; all trace drained after test_ending.

Behaviour:
Interface
- One clock, clk. Reset is synchronous and active-high, named reset.

Reset
- dct_buffer=0, dct_count=0, dct_valid=0, test_has_ended=0.
- Accumulator is empty; flush_pending=0; state=RUN.
- code_ready is a function of state, so it is 1 one cycle after reset deasserts.
- Reset mid-operation discards the accumulator and any unaccepted output word; nothing is emitted afterwards.

Accumulator
- Shift register acc[29:0] with count acc_cnt[3:0].
- Code accept = code_valid & code_ready.
- On accept: acc <= {acc[27:0], code_in}; acc_cnt++. The newest code is at bits[1:0], and the first code of a full word is at [29:28].
- Partial word with k codes: codes occupy [2k-1:0] and the upper bits are 0.

Output slot
- The output slot is free when !dct_valid | dct_ready.
- Transfer is evaluated on the post-accept accumulator value: acc_next, cnt_next.
- Transfer occurs when the slot is free and either:
  - cnt_next==SLOTS, or
  - (flush_pending | flush | state==ENDING) and cnt_next>0.
- On transfer: dct_buffer<=acc_next, dct_count<=cnt_next, dct_valid<=1, acc<=0, acc_cnt<=0, flush_pending<=0.
- Latency: the word appears on dct_valid the cycle after the 15th code is accepted, or after the flush cycle, if the slot was free.
- dct_buffer and dct_count stay stable while dct_valid & !dct_ready.
- dct_valid drops the cycle after dct_ready, unless a new transfer happens in that same cycle (back-to-back words allowed).

Backpressure
- code_ready = (state==RUN) & (acc_cnt<SLOTS). A full accumulator stalls until its transfer completes.
- flush while the slot is busy sets flush_pending. The partial word is emitted once the slot frees.
- flush with acc_cnt==0 and no accept emits nothing and clears flush_pending.
- flush in the same cycle as an accept includes the accepted code in the flushed word.

State machine
- RUN: go to ENDING when test_ending=1.
- ENDING:
  - code_ready=0.
  - Accumulator is flushed as above.
  - Go to ENDED when acc_cnt==0 and the slot is free (no dct_valid, or dct_valid & dct_ready).
- ENDED:
  - test_has_ended=1 from the cycle after entry.
  - Sticky until reset; code_ready=0; no further words.
- test_ending dropping after ENDING is entered is ignored.

Test Plan:
1. Reset, then hold dct_ready=1 and feed 15 codes of 2'b01 back-to-back -> one cycle after the 15th accept: dct_valid=1, dct_buffer=30'h15555555, dct_count=15; code_ready stays 1 throughout.
2. Feed codes 3,2,1, pulse flush -> next cycle: dct_buffer=30'h00000039, dct_count=3; a flush with an empty accumulator produces no word.
3. dct_ready=0 with a full word held, feed 15 more codes -> code_ready=0 after the 15th; dct_buffer stays stable. Raise dct_ready for 1 cycle -> second word presented the cycle after, with no gap or loss.
4. Flush pulsed while output busy with 4 codes queued -> word with dct_count=4 emitted the cycle after dct_ready frees the slot.
5. 7 codes buffered, then assert test_ending with dct_ready=1 -> code_ready=0, word with dct_count=7 emitted, test_has_ended=1 two cycles later and remains high.
6. Assert reset while dct_valid=1 and acc_cnt=9 -> next cycle dct_valid=0, dct_count=0, test_has_ended=0; subsequent 15 codes produce a clean full word.

Source files
------------

// File: rtl/nios2_qsys_oci_dct_packer.sv
// Packs 2-bit OCI data-trace codes into 30-bit buffer words with a slot count,
// hands them to the sink over valid/ready, and sequences the end-of-test drain.
module nios2_qsys_oci_dct_packer #(
  parameter int SLOTS  = 15,
  parameter int CODE_W = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      code_valid,
  input  logic [CODE_W-1:0]         code_in,
  output logic                      code_ready,
  input  logic                      flush,
  output logic [SLOTS*CODE_W-1:0]   dct_buffer,
  output logic [3:0]                dct_count,
  output logic                      dct_valid,
  input  logic                      dct_ready,
  input  logic                      test_ending,
  output logic                      test_has_ended
);

  localparam int W = SLOTS * CODE_W;
  localparam logic [3:0] FULL_CNT = 4'(SLOTS);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_ENDING = 2'd1;
  localparam logic [1:0] ST_ENDED  = 2'd2;

  logic [W-1:0] acc;
  logic [3:0]   acc_cnt;
  logic         flush_pending;
  logic [1:0]   state;

  logic         accept;
  logic [W-1:0] acc_next;
  logic [3:0]   cnt_next;
  logic         slot_free;
  logic         flush_req;
  logic         xfer;
  logic [1:0]   state_next;

  assign code_ready = (state == ST_RUN) && (acc_cnt < FULL_CNT);

  // Post-accept view of the accumulator and the transfer decision made on it.
  always_comb begin
    accept    = code_valid & code_ready;
    acc_next  = acc;
    cnt_next  = acc_cnt;
    if (accept) begin
      acc_next = {acc[W-CODE_W-1:0], code_in};
      cnt_next = acc_cnt + 4'd1;
    end else begin
      acc_next = acc;
      cnt_next = acc_cnt;
    end
    slot_free = !dct_valid || dct_ready;
    flush_req = flush_pending || flush || (state == ST_ENDING);
    xfer      = slot_free &&
                ((cnt_next == FULL_CNT) || (flush_req && (cnt_next != 4'd0)));
  end

  // Drain sequencing; ENDED only once the accumulator and output slot are both clear.
  always_comb begin
    state_next = state;
    case (state)
      ST_RUN: begin
        if (test_ending) state_next = ST_ENDING;
        else             state_next = ST_RUN;
      end
      ST_ENDING: begin
        if ((acc_cnt == 4'd0) && slot_free) state_next = ST_ENDED;
        else                                state_next = ST_ENDING;
      end
      ST_ENDED: state_next = ST_ENDED;
      default:  state_next = ST_RUN;
    endcase
  end

  // Accumulator, output slot and state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc            <= '0;
      acc_cnt        <= 4'd0;
      flush_pending  <= 1'b0;
      state          <= ST_RUN;
      dct_buffer     <= '0;
      dct_count      <= 4'd0;
      dct_valid      <= 1'b0;
      test_has_ended <= 1'b0;
    end else begin
      state          <= state_next;
      test_has_ended <= (state == ST_ENDED);
      if (xfer) begin
        dct_buffer    <= acc_next;
        dct_count     <= cnt_next;
        dct_valid     <= 1'b1;
        acc           <= '0;
        acc_cnt       <= 4'd0;
        flush_pending <= 1'b0;
      end else begin
        acc     <= acc_next;
        acc_cnt <= cnt_next;
        if (slot_free) dct_valid <= 1'b0;
        // A flush that cannot go out now is remembered, unless there is nothing to send.
        if (flush) flush_pending <= (cnt_next != 4'd0);
      end
    end
  end

endmodule

// File: tb/tb_nios2_qsys_oci_dct_packer.sv
// Directed and randomized bench for nios2_qsys_oci_dct_packer against a
// queue-based reference model of the packing and drain rules.
module tb_nios2_qsys_oci_dct_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        code_valid;
  logic [1:0]  code_in;
  logic        code_ready;
  logic        flush;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        dct_valid;
  logic        dct_ready;
  logic        test_ending;
  logic        test_has_ended;

  int checks = 0;
  int errors = 0;

  // reference model: pending codes oldest-first, plus the presented word
  int          mq[$];
  bit          m_valid;
  logic [29:0] m_buf;
  logic [3:0]  m_cnt;
  bit          m_pend;
  int          m_phase;   // 0 running, 1 draining, 2 drained
  bit          m_ended;
  int          m_acc_total;

  nios2_qsys_oci_dct_packer #(.SLOTS(15), .CODE_W(2)) dut (
    .clk(clk), .reset(reset), .code_valid(code_valid), .code_in(code_in),
    .code_ready(code_ready), .flush(flush), .dct_buffer(dct_buffer),
    .dct_count(dct_count), .dct_valid(dct_valid), .dct_ready(dct_ready),
    .test_ending(test_ending), .test_has_ended(test_has_ended)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [29:0] pack_codes();
    longint v = 0;
    foreach (mq[i]) v = v * 4 + longint'(mq[i]);
    return 30'(v);
  endfunction

  function automatic void model_step();
    int n_before;
    bit rdy, free, want;
    if (reset) begin
      mq.delete();
      m_valid = 1'b0; m_buf = 30'd0; m_cnt = 4'd0;
      m_pend = 1'b0; m_phase = 0; m_ended = 1'b0;
      return;
    end
    rdy      = (m_phase == 0) && (mq.size() < 15);
    n_before = mq.size();
    m_ended  = m_ended || (m_phase == 2);
    if (code_valid && rdy) begin
      mq.push_back(int'(code_in));
      m_acc_total++;
    end
    free = !m_valid || dct_ready;
    want = (mq.size() == 15) || ((m_pend || flush || m_phase == 1) && mq.size() > 0);
    if (free && want) begin
      m_buf = pack_codes();
      m_cnt = 4'(mq.size());
      m_valid = 1'b1;
      mq.delete();
      m_pend = 1'b0;
    end else begin
      if (free) m_valid = 1'b0;
      if (flush) m_pend = (mq.size() > 0);
    end
    if (m_phase == 0 && test_ending) m_phase = 1;
    else if (m_phase == 1 && n_before == 0 && free) m_phase = 2;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("dct_valid", 32'(dct_valid), 32'(m_valid));
    chk("dct_buffer", 32'(dct_buffer), 32'(m_buf));
    chk("dct_count", 32'(dct_count), 32'(m_cnt));
    chk("test_has_ended", 32'(test_has_ended), 32'(m_ended));
    chk("code_ready", 32'(code_ready), 32'((m_phase == 0) && (mq.size() < 15)));
  endtask

  // code < 0 means random codes
  task automatic feed(input int n, input int code);
    int start = m_acc_total;
    int budget = 300;
    while ((m_acc_total - start) < n && budget > 0) begin
      code_valid = 1'b1;
      code_in = (code < 0) ? 2'($urandom_range(3, 0)) : 2'(code);
      tick();
      budget--;
    end
    code_valid = 1'b0;
    checks++;
    assert ((m_acc_total - start) == n) else begin
      errors++;
      $error("FAIL feed_timeout observed=%0d expected=%0d", m_acc_total - start, n);
    end
  endtask

  logic [29:0] held;

  initial begin
    reset = 1'b1; code_valid = 1'b0; code_in = 2'd0; flush = 1'b0;
    dct_ready = 1'b0; test_ending = 1'b0; m_acc_total = 0;
    tick(); tick();
    chk("reset_valid", 32'(dct_valid), 32'd0);
    chk("reset_count", 32'(dct_count), 32'd0);
    reset = 1'b0;
    tick();
    chk("ready_after_reset", 32'(code_ready), 32'd1);

    // 1: full word of 2'b01
    dct_ready = 1'b1;
    feed(15, 1);
    chk("t1_buf", 32'(dct_buffer), 32'h15555555);
    chk("t1_cnt", 32'(dct_count), 32'd15);
    chk("t1_valid", 32'(dct_valid), 32'd1);

    // 2: partial word flushed with the last accepted code
    feed(1, 3); feed(1, 2);
    code_valid = 1'b1; code_in = 2'd1; flush = 1'b1;
    tick();
    code_valid = 1'b0; flush = 1'b0;
    chk("t2_buf", 32'(dct_buffer), 32'h00000039);
    chk("t2_cnt", 32'(dct_count), 32'd3);
    flush = 1'b1; tick(); flush = 1'b0;
    tick();
    chk("t2_empty_flush", 32'(dct_valid), 32'd0);

    // 3: backpressure with a full word held
    dct_ready = 1'b0;
    feed(15, -1);
    held = dct_buffer;
    feed(15, -1);
    chk("t3_stall_ready", 32'(code_ready), 32'd0);
    tick(); tick();
    chk("t3_stable", 32'(dct_buffer), 32'(held));
    dct_ready = 1'b1; tick(); dct_ready = 1'b0;
    chk("t3_second_valid", 32'(dct_valid), 32'd1);
    chk("t3_second_cnt", 32'(dct_count), 32'd15);

    // 4: flush while busy
    feed(4, -1);
    flush = 1'b1; tick(); flush = 1'b0;
    tick();
    chk("t4_still_old", 32'(dct_count), 32'd15);
    dct_ready = 1'b1; tick();
    chk("t4_cnt", 32'(dct_count), 32'd4);
    chk("t4_valid", 32'(dct_valid), 32'd1);

    // 5: end-of-test drain
    tick();
    feed(7, -1);
    test_ending = 1'b1; tick();
    chk("t5_ready_low", 32'(code_ready), 32'd0);
    tick();
    chk("t5_cnt", 32'(dct_count), 32'd7);
    test_ending = 1'b0;
    tick(); tick();
    chk("t5_ended", 32'(test_has_ended), 32'd1);
    repeat (5) tick();
    chk("t5_sticky", 32'(test_has_ended), 32'd1);

    // 6: reset mid-operation
    reset = 1'b1; tick(); reset = 1'b0; dct_ready = 1'b0;
    feed(15, -1);
    feed(9, -1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("t6_valid", 32'(dct_valid), 32'd0);
    chk("t6_cnt", 32'(dct_count), 32'd0);
    chk("t6_ended", 32'(test_has_ended), 32'd0);
    dct_ready = 1'b1;
    feed(15, 2);
    chk("t6_buf", 32'(dct_buffer), 32'h2AAAAAAA);
    chk("t6_full_cnt", 32'(dct_count), 32'd15);

    // randomized traffic, then drain
    for (int i = 0; i < 600; i++) begin
      code_valid = 1'($urandom_range(1, 0));
      code_in    = 2'($urandom_range(3, 0));
      flush      = ($urandom_range(9, 0) == 0);
      dct_ready  = ($urandom_range(9, 0) < 6);
      tick();
    end
    flush = 1'b0;
    test_ending = 1'b1;
    for (int i = 0; i < 200 && !test_has_ended; i++) begin
      code_valid = 1'($urandom_range(1, 0));
      dct_ready  = 1'($urandom_range(1, 0));
      tick();
    end
    chk("rand_drained", 32'(test_has_ended), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
